// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between a pipeline stage register and its neighbours.
// The master drives the i_* side (upstream stage and hazard unit); the slave is the stage register.
interface pipe_stage_reg_if #(
   parameter int WD_W   = 32,
   parameter int TNEW_W = 2,
   parameter int HOLD_W = 4
);
   logic              i_stall;
   logic              i_flush;
   logic              i_valid;
   logic [31:0]       i_instr;
   logic [31:0]       i_pc;
   logic [4:0]        i_a3;
   logic              i_reg_we;
   logic [WD_W-1:0]   i_wd;
   logic [TNEW_W-1:0] i_tnew;
   logic              o_valid;
   logic [31:0]       o_instr;
   logic [31:0]       o_pc;
   logic [4:0]        o_a3;
   logic              o_reg_we;
   logic [WD_W-1:0]   o_wd;
   logic [TNEW_W-1:0] o_tnew;
   logic [HOLD_W-1:0] o_hold_cnt;

   modport master (
      output i_stall, i_flush, i_valid, i_instr, i_pc, i_a3, i_reg_we, i_wd, i_tnew,
      input  o_valid, o_instr, o_pc, o_a3, o_reg_we, o_wd, o_tnew, o_hold_cnt
   );

   modport slave (
      input  i_stall, i_flush, i_valid, i_instr, i_pc, i_a3, i_reg_we, i_wd, i_tnew,
      output o_valid, o_instr, o_pc, o_a3, o_reg_we, o_wd, o_tnew, o_hold_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the 5-stage MIPS core with stall/flush, valid tracking,
// a decrementing Tnew hazard tag and a saturating consecutive-stall counter.
module pipe_stage_reg #(
   parameter int WD_W     = 32,
   parameter int TNEW_W   = 2,
   parameter int TNEW_DEC = 1,
   parameter int HOLD_W   = 4
) (
   input logic             i_clk,
   input logic             i_reset,
   pipe_stage_reg_if.slave bus
);
   localparam logic [31:0]       DEC_32 = TNEW_DEC;
   localparam logic [TNEW_W-1:0] DEC_N  = DEC_32[TNEW_W-1:0];

   logic              r_valid;
   logic [31:0]       r_instr;
   logic [31:0]       r_pc;
   logic [4:0]        r_a3;
   logic              r_reg_we;
   logic [WD_W-1:0]   r_wd;
   logic [TNEW_W-1:0] r_tnew;
   logic [HOLD_W-1:0] r_hold;

   logic              w_valid;
   logic [31:0]       w_instr;
   logic [31:0]       w_pc;
   logic [4:0]        w_a3;
   logic              w_reg_we;
   logic [WD_W-1:0]   w_wd;
   logic [TNEW_W-1:0] w_tnew;
   logic [HOLD_W-1:0] w_hold;
   logic [31:0]       w_tnew_ext;

   assign w_tnew_ext = {{(32-TNEW_W){1'b0}}, bus.i_tnew};

   // Next-state selection: Flush > Stall > Load (reset handled in the register block).
   always_comb begin
      w_valid  = r_valid;
      w_instr  = r_instr;
      w_pc     = r_pc;
      w_a3     = r_a3;
      w_reg_we = r_reg_we;
      w_wd     = r_wd;
      w_tnew   = r_tnew;
      w_hold   = r_hold;
      if (bus.i_flush) begin
         // Bubble keeps the PC so a squashed slot can still be traced.
         w_valid  = 1'b0;
         w_instr  = 32'h0000_0000;
         w_pc     = bus.i_pc;
         w_a3     = 5'd0;
         w_reg_we = 1'b0;
         w_wd     = {WD_W{1'b0}};
         w_tnew   = {TNEW_W{1'b0}};
         w_hold   = {HOLD_W{1'b0}};
      end else if (bus.i_stall) begin
         if (r_hold != {HOLD_W{1'b1}}) begin
            w_hold = r_hold + {{(HOLD_W-1){1'b0}}, 1'b1};
         end else begin
            w_hold = r_hold;
         end
      end else begin
         w_valid  = bus.i_valid;
         w_pc     = bus.i_pc;
         w_wd     = bus.i_wd;
         w_hold   = {HOLD_W{1'b0}};
         // $0 is hardwired, so a write to it is never advertised downstream.
         w_reg_we = bus.i_reg_we & bus.i_valid & (bus.i_a3 != 5'd0);
         if (bus.i_valid) begin
            w_instr = bus.i_instr;
            w_a3    = bus.i_a3;
            if (w_tnew_ext > DEC_32) begin
               w_tnew = bus.i_tnew - DEC_N;
            end else begin
               w_tnew = {TNEW_W{1'b0}};
            end
         end else begin
            w_instr = 32'h0000_0000;
            w_a3    = 5'd0;
            w_tnew  = {TNEW_W{1'b0}};
         end
      end
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_valid  <= 1'b0;
         r_instr  <= 32'h0000_0000;
         r_pc     <= 32'h0000_0000;
         r_a3     <= 5'd0;
         r_reg_we <= 1'b0;
         r_wd     <= {WD_W{1'b0}};
         r_tnew   <= {TNEW_W{1'b0}};
         r_hold   <= {HOLD_W{1'b0}};
      end else begin
         r_valid  <= w_valid;
         r_instr  <= w_instr;
         r_pc     <= w_pc;
         r_a3     <= w_a3;
         r_reg_we <= w_reg_we;
         r_wd     <= w_wd;
         r_tnew   <= w_tnew;
         r_hold   <= w_hold;
      end
   end

   assign bus.o_valid    = r_valid;
   assign bus.o_instr    = r_instr;
   assign bus.o_pc       = r_pc;
   assign bus.o_a3       = r_a3;
   assign bus.o_reg_we   = r_reg_we;
   assign bus.o_wd       = r_wd;
   assign bus.o_tnew     = r_tnew;
   assign bus.o_hold_cnt = r_hold;
endmodule
